rr_mux4_arbiter: RTL
====================

Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares a 4-input one-hot-selected multiplexer among four requesters.
- Each requester presents a K-bit word with a request line. The arbiter picks one requester fairly and drives the one-hot select. It captures the selected word into a single-entry output register and hands it downstream with a valid/ready handshake.
- Sits in front of the team's one-hot 4:1 mux datapath as its sequencing and ownership controller.

Parameters:
- k, 1, data width of each requester word and of out_data (same meaning as the mux width parameter).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i pairs with a_i.
- a0  input  k  requester 0 data; must be held stable while req[0]=1 and gnt[0]=0.
- a1  input  k  requester 1 data; same rule.
- a2  input  k  requester 2 data; same rule.
- a3  input  k  requester 3 data; same rule.
- gnt  output  4  one-hot accept strobe; combinational; gnt[i]=1 means a_i is captured at this rising edge.
- sel  output  4  registered one-hot owner of the word currently in out_data; 4'b0000 when empty.
- out_valid  output  1  output register holds a word.
- out_data  output  k  captured word.
- out_ready  input  1  downstream accepts out_data when out_valid=1 and out_ready=1.

Behaviour:
- Fixed clocking: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (asynchronous, take effect immediately):
  - out_valid=0, out_data=0, sel=4'b0000.
  - Priority pointer ptr=4'b0001, i.e. requester 0 has highest priority.
  - gnt forced to 4'b0000 while rst_n=0.
- States: EMPTY (out_valid=0) and FULL (out_valid=1). Explicit 1-bit state register; out_valid equals the state.
- Arbitration (combinational):
  - Search req starting at the bit set in ptr, then upward with wrap 3->0.
  - The first set bit is the winner, one-hot w.
  - w=0 when req=0.
- load = (state==EMPTY or out_ready==1) and req!=0.
- gnt = load ? w : 4'b0000. At most one bit is ever set.
- On a rising edge with load=1:
  - out_data <= word selected by w, with exactly the one-hot mux semantics.
  - sel <= w; state <= FULL.
  - ptr <= w rotated left by 1, so the winner becomes lowest priority.
- On a rising edge with state==FULL, out_ready=1 and req=0: state <= EMPTY, sel <= 0. out_data holds its last value.
- FULL with out_ready=0: out_data, sel and ptr are frozen; gnt=0.
- Back-to-back transfers:
  - Acceptance and a new capture happen on the same edge, so one word moves per cycle at full throughput.
  - ptr is unchanged when no load occurs.
- Latency: a word captured at edge N is visible on out_data and out_valid after edge N. There is zero bubble on a continuous stream.
- Requester rule: a requester samples gnt[i]. After the edge where gnt[i]=1 it either drops req[i] or presents its next word.
- Fairness: a continuously asserted requester is granted within 4 loads.
- req changing while not granted: re-evaluated every cycle; no latching of requests.
- Reset mid-transfer: the held word is discarded, out_valid drops immediately, and no gnt is issued until rst_n=1.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, out_valid=0, sel=0, out_data=0. After release, first edge grants requester 0 (gnt=4'b0001).
- Single requester, k=8: req=4'b0100, a2=8'hA5, out_ready=1 -> gnt=4'b0100 that cycle. Next cycle out_valid=1, out_data=8'hA5, sel=4'b0100. With req dropped, following cycle out_valid=0.
- Round robin, all four requesting continuously, out_ready=1 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles, with out_data tracking a0,a1,a2,a3,a0 one cycle later.
- Backpressure: FULL holding 8'h3C, out_ready=0 for 5 cycles while req=4'b1010 -> gnt=0, out_data=8'h3C and sel stable. On out_ready=1 the next winner is captured per ptr in that same cycle.
- Pointer wrap: after a grant to requester 3, req=4'b1001 -> requester 0 granted before requester 3.
- Async reset while FULL (out_ready=0) -> out_valid=0 and sel=0 without a clock edge. On release with req=4'b1000 -> gnt=4'b1000 with ptr restarted at 4'b0001.

Source files
------------

// File: rtl/rr_mux4_arbiter_if.sv
// Bundle of the requester, grant and output handshake signals around
// rr_mux4_arbiter.
//   req        : per-requester request; bit i pairs with ai
//   a0..a3     : requester words, k bits each
//   gnt        : one-hot accept strobe (combinational, from the arbiter)
//   sel        : registered one-hot owner of out_data, 0 when empty
//   out_valid  : output register holds a word
//   out_data   : captured word
//   out_ready  : downstream accept
// The master modport is the environment side (requesters + downstream).
// The slave modport is the arbiter side.
interface rr_mux4_arbiter_if #(
  parameter int unsigned k = 1
);
  logic [3:0]   req;
  logic [k-1:0] a0;
  logic [k-1:0] a1;
  logic [k-1:0] a2;
  logic [k-1:0] a3;
  logic [3:0]   gnt;
  logic [3:0]   sel;
  logic         out_valid;
  logic [k-1:0] out_data;
  logic         out_ready;

  modport master (
    output req, a0, a1, a2, a3, out_ready,
    input  gnt, sel, out_valid, out_data
  );

  modport slave (
    input  req, a0, a1, a2, a3, out_ready,
    output gnt, sel, out_valid, out_data
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter that owns a one-hot 4:1 mux and a single-entry
// output register with a valid/ready handshake.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_mux4_arbiter_if.slave (req, a0..a3, gnt, sel, out_valid,
//           out_data, out_ready)
// A word is captured whenever the register is empty or being drained in
// the same cycle, so a continuous stream moves one word per cycle.
module rr_mux4_arbiter #(
  parameter int unsigned k = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux4_arbiter_if.slave  bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [3:0]   ptr_q, ptr_d;
  logic [3:0]   sel_q, sel_d;
  logic [k-1:0] data_q, data_d;

  logic [3:0]   win;
  logic         load;
  logic [k-1:0] mux_word;

  // Winner search: start at the bit set in ptr_q and walk upward with wrap.
  always_comb begin
    logic [1:0] idx;
    win = '0;
    idx = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      if (ptr_q[s]) begin
        for (int unsigned j = 0; j < 4; j++) begin
          idx = 2'(s + j);
          if (bus.req[idx] && (win == '0)) begin
            win[idx] = 1'b1;
          end
        end
      end
    end
  end

  assign load = ((state_q == EMPTY) || bus.out_ready) && (bus.req != '0);

  // One-hot AND-OR mux; win is one-hot or zero.
  assign mux_word = ({k{win[0]}} & bus.a0) |
                    ({k{win[1]}} & bus.a1) |
                    ({k{win[2]}} & bus.a2) |
                    ({k{win[3]}} & bus.a3);

  // rst_n gates gnt so no accept strobe escapes while reset is held.
  assign bus.gnt       = (rst_n && load) ? win : '0;
  assign bus.sel       = sel_q;
  assign bus.out_valid = state_q;
  assign bus.out_data  = data_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (load) begin
      data_d  = mux_word;
      sel_d   = win;
      state_d = FULL;
      ptr_d   = {win[2:0], win[3]};
    end else if ((state_q == FULL) && bus.out_ready) begin
      // Drained with nothing pending; out_data keeps its last value.
      state_d = EMPTY;
      sel_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= 4'b0001;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

endmodule
